mult_8bit_seq: RTL

- Sequential 8x8 unsigned shift-add multiplier producing a 16-bit product.
- Sits directly downstream of the existing combinational adder_8bit: it instantiates that adder and consumes its 8-bit Sum once per iteration.
- It gives the ALU a multiply operation using the existing add datapath, with a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/adder_8bit.sv | 20 ++
 rtl/mult_8bit_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU constants. Holds the datapath width, the
//               multiplier FSM state encodings and the shift-add iteration
//               count.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Datapath width shared by adder_8bit and mult_8bit_seq
  localparam int ALU_WIDTH = 8;

  // Multiplier FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One shift-add iteration per multiplier bit
  localparam int ITER_COUNT = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } mult_state_t;

endpackage
`default_nettype wire

// File: rtl/adder_8bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_8bit
// Description : Combinational 8-bit adder with no carry-out. The sum wraps
//               modulo 256.
// Ports       : A   [7:0] in  - addend
//               B   [7:0] in  - addend
//               Sum [7:0] out - (A + B) mod 256
// Revision    : 1.0 - initial release
// ============================================================================
module adder_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Sum
);

  assign Sum = A + B;

endmodule
`default_nettype wire

// File: rtl/mult_8bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult_8bit_seq
// Description : Sequential 8x8 unsigned shift-add multiplier built on the
//               existing adder_8bit. A start accepted in IDLE or DONE runs
//               eight iterations; the 16-bit product is valid with a
//               one-cycle done pulse 8 edges after acceptance.
// Ports       : clk           in  - rising-edge clock
//               rst           in  - asynchronous active-high reset
//               start         in  - request, sampled only in IDLE or DONE
//               a       [7:0] in  - multiplicand, latched on accepted start
//               b       [7:0] in  - multiplier, latched on accepted start
//               busy          out - high while iterating
//               done          out - one-cycle pulse when product updates
//               product [15:0]out - a*b, held until next completion/reset
// Revision    : 1.0 - initial release
// ============================================================================
module mult_8bit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH   // only 8 is supported (adder width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [3:0] c_last_iter = 4'(ITER_COUNT - 1);

  mult_state_t        r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic [3:0]         r_cnt;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_mq_nxt;

  adder_8bit u_adder (
    .A   (r_acc),
    .B   (r_mcand),
    .Sum (w_sum)
  );

  // The adder has no carry-out; an unsigned add wrapped iff the result is
  // smaller than either operand.
  assign w_carry = (w_sum < r_acc);

  // {acc,mq} treated as one register shifted right by one each iteration,
  // with the add result (plus its carry) injected when the multiplier LSB is 1.
  always_comb begin
    w_acc_nxt = {1'b0, r_acc[WIDTH-1:1]};
    w_mq_nxt  = {r_acc[0], r_mq[WIDTH-1:1]};
    if (r_mq[0]) begin
      w_acc_nxt = {w_carry, w_sum[WIDTH-1:1]};
      w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mq      <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_mq  <= w_mq_nxt;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == c_last_iter) begin
            r_product <= {w_acc_nxt, w_mq_nxt};
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        // IDLE and DONE accept a new request identically; DONE always
        // lasts a single cycle.
        default: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= a;
            r_mq    <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign product = r_product;

endmodule
`default_nettype wire
